pixel_packer: RTL and testbench

Converts a stream of 24-bit RGB pixels, one pixel per handshake, into a 32-bit AXI4-Stream video stream. Every 4 pixels become 3 words. It sits between the fractal pixel generator and the stream output (VDMA) port. It carries start-of-frame on `tuser` and end-of-line on `tlast`, and applies backpressure to the generator through `in_stream_ready`.

---
 rtl/pixel_packer_pkg.sv | 69 ++++++
 rtl/pixel_packer.sv | 143 ++++++++++++++
 tb/tb_pixel_packer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_packer_pkg.sv
// pixel_packer_pkg
// Shared constants and helpers for the 24-bit RGB to 32-bit stream packer.
//   PIX_W / WORD_W : pixel and output word widths
//   phase_e        : position of the next pixel inside a 4-pixel / 3-word group
//   TKEEP_ALL      : every output byte is valid
//   pack_word      : output word for a pixel at a given phase
//   next_residue   : bytes left over after that pixel
//   next_phase     : phase that follows a given phase
package pixel_packer_pkg;

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned WORD_W = 32;

  localparam logic [3:0] TKEEP_ALL = 4'hF;

  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2,
    PH_3 = 2'd3
  } phase_e;

  // The pixels form a little-endian byte stream: the residue always holds
  // the oldest unsent bytes in its low positions.
  function automatic logic [WORD_W-1:0] pack_word(
    input phase_e           ph,
    input logic [PIX_W-1:0] res,
    input logic [PIX_W-1:0] pix
  );
    logic [WORD_W-1:0] w;
    case (ph)
      PH_1:    w = {pix[7:0], res};
      PH_2:    w = {pix[15:0], res[15:0]};
      PH_3:    w = {pix, res[7:0]};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [PIX_W-1:0] next_residue(
    input phase_e           ph,
    input logic [PIX_W-1:0] res,
    input logic [PIX_W-1:0] pix
  );
    logic [PIX_W-1:0] n;
    case (ph)
      PH_0:    n = pix;
      PH_1:    n = {8'h00, pix[23:8]};
      PH_2:    n = {16'h0000, pix[23:16]};
      default: n = '0;
    endcase
    // res is unused at this point; the whole residue is consumed by the
    // word built in pack_word.
    if (ph == PH_3) n = res & '0;
    return n;
  endfunction

  function automatic phase_e next_phase(input phase_e ph);
    phase_e n;
    case (ph)
      PH_0:    n = PH_1;
      PH_1:    n = PH_2;
      PH_2:    n = PH_3;
      default: n = PH_0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// pixel_packer
// Packs one 24-bit RGB pixel per handshake into a 32-bit AXI4-Stream video
// stream: every 4 pixels become 3 words. Start-of-frame travels on tuser,
// end-of-line on tlast.
//
// Ports
//   aclk, aresetn       : clock, asynchronous active-low reset
//   r, g, b             : pixel components, pixel P = {r,g,b}
//   valid, sof, eol     : pixel qualifier, first pixel of frame, last of line
//   in_stream_ready     : pixel is accepted on an edge when valid && ready
//   out_stream_tdata    : packed output word
//   out_stream_tkeep    : constant all-bytes-valid
//   out_stream_tlast    : end-of-line marker
//   out_stream_tuser    : start-of-frame marker
//   out_stream_tvalid   : output word valid
//   out_stream_tready   : downstream accepts the word
//
// Handshake: on the output side a word transfers on an edge where
// tvalid && tready; tvalid, once high, stays high with tdata/tlast/tuser
// stable until that edge. On the input side a pixel transfers on an edge
// where valid && in_stream_ready; ready only depends on the output register
// being free (or being drained on the same edge), so a new word can replace
// a departing one without a bubble.
module pixel_packer
  import pixel_packer_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready
);

  logic [PIX_W-1:0] pix;

  phase_e           phase_q, phase_d;
  phase_e           phase_eff;
  logic [PIX_W-1:0] res_q, res_d;
  logic             sof_pend_q, sof_pend_d;

  logic [WORD_W-1:0] tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              tuser_q, tuser_d;
  logic              tvalid_q, tvalid_d;

  logic              accept;
  logic              emit;
  logic [WORD_W-1:0] word;

  assign pix = {r, g, b};

  // Ready is forced low during reset so no pixel is taken while the
  // registers are being cleared.
  assign in_stream_ready = aresetn & (~tvalid_q | out_stream_tready);
  assign accept          = valid & in_stream_ready;

  // A start-of-frame pixel always opens a new group, dropping any partial
  // residue left from the previous frame.
  assign phase_eff = sof ? PH_0 : phase_q;

  assign word = pack_word(phase_eff, res_q, pix);

  always_comb begin
    phase_d    = phase_q;
    res_d      = res_q;
    sof_pend_d = sof_pend_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    tvalid_d   = tvalid_q;
    emit       = 1'b0;

    // Word leaves; cleared here and re-set below if a new one arrives.
    if (tvalid_q && out_stream_tready) begin
      tvalid_d = 1'b0;
    end

    if (accept) begin
      emit  = (phase_eff != PH_0);
      res_d = next_residue(phase_eff, res_q, pix);

      if (sof) begin
        sof_pend_d = 1'b1;
      end

      // End of line closes the group; an eol pixel at phase 0 has nothing
      // complete to send, so its bytes are simply dropped.
      if (eol) begin
        phase_d = PH_0;
        res_d   = '0;
      end else begin
        phase_d = next_phase(phase_eff);
      end

      // A sof pixel is always at phase 0, so it never emits; the pending
      // flag therefore marks the first word built after it.
      if (emit) begin
        tdata_d    = word;
        tlast_d    = eol;
        tuser_d    = sof_pend_q;
        tvalid_d   = 1'b1;
        sof_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q    <= PH_0;
      res_q      <= '0;
      sof_pend_q <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      tvalid_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      res_q      <= res_d;
      sof_pend_q <= sof_pend_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      tvalid_q   <= tvalid_d;
    end
  end

  assign out_stream_tdata  = tdata_q;
  assign out_stream_tkeep  = TKEEP_ALL;
  assign out_stream_tlast  = tlast_q;
  assign out_stream_tuser  = tuser_q;
  assign out_stream_tvalid = tvalid_q;

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer
// Self-checking bench for pixel_packer. Expected words come from a byte-queue
// model of the little-endian packing rule.
module tb_pixel_packer;

  logic        aclk;
  logic        aresetn;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready;

  pixel_packer dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int unsigned cycle_cnt = 0;
  always @(posedge aclk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- scoreboard / model ----------------
  // exp_q entries: {tuser, tlast, tdata}
  logic [33:0] exp_q[$];
  logic [7:0]  byte_q[$];
  logic        model_pend = 1'b0;

  int unsigned words_seen = 0;
  int unsigned user_seen  = 0;
  int unsigned last_seen  = 0;
  logic [31:0] last_data  = '0;
  logic        last_user  = 1'b0;
  logic        last_last  = 1'b0;

  function automatic void model_accept(input logic [23:0] p, input logic s, input logic e);
    logic [31:0] w;
    if (s) begin
      byte_q.delete();
      model_pend = 1'b1;
    end
    byte_q.push_back(p[7:0]);
    byte_q.push_back(p[15:8]);
    byte_q.push_back(p[23:16]);
    if (byte_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) w[8*i +: 8] = byte_q.pop_front();
      exp_q.push_back({model_pend, e, w});
      model_pend = 1'b0;
    end
    if (e) byte_q.delete();
  endfunction

  // Sampled on the falling edge: everything seen here is what the next
  // rising edge will act on.
  always @(negedge aclk) begin
    logic exp_ready;
    logic [33:0] f;
    if (!aresetn) begin
      check("rst_tvalid", 64'(out_stream_tvalid), 64'd0);
      check("rst_ready",  64'(in_stream_ready),   64'd0);
      check("rst_tdata",  64'(out_stream_tdata),  64'd0);
      check("rst_tlast",  64'(out_stream_tlast),  64'd0);
      check("rst_tuser",  64'(out_stream_tuser),  64'd0);
      exp_q.delete();
      byte_q.delete();
      model_pend = 1'b0;
    end else begin
      exp_ready = (exp_q.size() == 0) || out_stream_tready;
      check("tvalid", 64'(out_stream_tvalid), 64'(exp_q.size() != 0));
      check("ready",  64'(in_stream_ready),   64'(exp_ready));
      if (exp_q.size() != 0) begin
        f = exp_q[0];
        check("tdata", 64'(out_stream_tdata), 64'(f[31:0]));
        check("tlast", 64'(out_stream_tlast), 64'(f[32]));
        check("tuser", 64'(out_stream_tuser), 64'(f[33]));
        check("tkeep", 64'(out_stream_tkeep), 64'hF);
        if (out_stream_tready) begin
          void'(exp_q.pop_front());
          words_seen++;
          if (f[33]) user_seen++;
          if (f[32]) last_seen++;
          last_data = f[31:0];
          last_user = f[33];
          last_last = f[32];
        end
      end
      if (valid && exp_ready) model_accept({r, g, b}, sof, eol);
    end
  end

  // ---------------- driver tasks ----------------
  logic rand_ready = 1'b0;
  always @(posedge aclk) begin
    if (rand_ready) begin
      #1;
      out_stream_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_pixel(input logic [23:0] p, input logic s, input logic e);
    logic acc;
    int   n;
    {r, g, b} = p;
    valid = 1'b1;
    sof   = s;
    eol   = e;
    n     = 0;
    do begin
      @(negedge aclk);
      acc = in_stream_ready;
      @(posedge aclk);
      #1;
      n++;
    end while (!acc && n < 500);
    check("send_accepted", 64'(acc), 64'd1);
    valid = 1'b0;
    sof   = 1'b0;
    eol   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      {r, g, b} = 24'($urandom);
      sof = 1'($urandom);
      eol = 1'($urandom);
      @(posedge aclk);
      #1;
    end
    sof = 1'b0;
    eol = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int unsigned w0, u0, l0, c0;
    logic [23:0] sp;

    aresetn = 1'b0;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    {r, g, b} = 24'h0;
    out_stream_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    out_stream_tready = 1'b1;

    // basic packing
    w0 = words_seen;
    send_pixel(24'h010203, 1'b0, 1'b0);
    send_pixel(24'h040506, 1'b0, 1'b0);
    send_pixel(24'h070809, 1'b0, 1'b0);
    send_pixel(24'h0A0B0C, 1'b0, 1'b0);
    drain();
    check("basic_words", 64'(words_seen - w0), 64'd3);
    check("basic_last_word", 64'(last_data), 64'h0A0B0C07);

    // backpressure
    w0 = words_seen;
    out_stream_tready = 1'b0;
    fork
      begin
        send_pixel(24'h010203, 1'b0, 1'b0);
        send_pixel(24'h040506, 1'b0, 1'b0);
        send_pixel(24'h070809, 1'b0, 1'b0);
        send_pixel(24'h0A0B0C, 1'b0, 1'b0);
      end
      begin
        repeat (6) @(posedge aclk);
        @(negedge aclk);
        check("bp_ready_low", 64'(in_stream_ready), 64'd0);
        check("bp_tvalid",    64'(out_stream_tvalid), 64'd1);
        check("bp_tdata_hold", 64'(out_stream_tdata), 64'h06010203);
        @(posedge aclk);
        #1;
        out_stream_tready = 1'b1;
      end
    join
    drain();
    check("bp_words", 64'(words_seen - w0), 64'd3);
    check("bp_last_word", 64'(last_data), 64'h0A0B0C07);

    // sof at phase 2
    sp = 24'hA1B2C3;
    send_pixel(24'h111111, 1'b0, 1'b0);
    send_pixel(24'h222222, 1'b0, 1'b0);
    send_pixel(sp, 1'b1, 1'b0);
    send_pixel(24'h445566, 1'b0, 1'b0);
    drain();
    check("sof_tuser", 64'(last_user), 64'd1);
    check("sof_bytes", 64'(last_data[23:0]), 64'(sp));
    check("sof_byte3", 64'(last_data[31:24]), 64'h66);
    send_pixel(24'h778899, 1'b0, 1'b0);
    send_pixel(24'hAABBCC, 1'b0, 1'b1);
    drain();
    check("sof_later_tuser", 64'(last_user), 64'd0);
    check("eol_p3_tlast", 64'(last_last), 64'd1);

    // eol on a phase-1 pixel, then a fresh group
    w0 = words_seen;
    send_pixel(24'h010203, 1'b0, 1'b0);
    send_pixel(24'h040506, 1'b0, 1'b1);
    drain();
    check("eol_p1_words", 64'(words_seen - w0), 64'd1);
    check("eol_p1_tlast", 64'(last_last), 64'd1);
    check("eol_p1_word", 64'(last_data), 64'h06010203);
    w0 = words_seen;
    send_pixel(24'h010203, 1'b0, 1'b0);
    send_pixel(24'h040506, 1'b0, 1'b0);
    drain();
    check("after_eol_phase0", 64'(last_data), 64'h06010203);
    check("after_eol_tlast", 64'(last_last), 64'd0);
    send_pixel(24'h070809, 1'b0, 1'b0);
    send_pixel(24'h0A0B0C, 1'b0, 1'b1);
    drain();
    check("after_eol_words", 64'(words_seen - w0), 64'd3);

    // reset mid-group with a word pending
    out_stream_tready = 1'b0;
    send_pixel(24'hDEAD01, 1'b0, 1'b0);
    send_pixel(24'hDEAD02, 1'b0, 1'b0);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    out_stream_tready = 1'b1;
    w0 = words_seen;
    send_pixel(24'h010203, 1'b0, 1'b0);
    send_pixel(24'h040506, 1'b0, 1'b0);
    send_pixel(24'h070809, 1'b0, 1'b0);
    send_pixel(24'h0A0B0C, 1'b0, 1'b0);
    drain();
    check("rst_mid_words", 64'(words_seen - w0), 64'd3);
    check("rst_mid_last", 64'(last_data), 64'h0A0B0C07);

    // randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_pixel(24'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end
    rand_ready = 1'b0;
    @(posedge aclk);
    #2;
    out_stream_tready = 1'b1;
    drain();

    // full 1920-pixel line at full rate
    w0 = words_seen;
    u0 = user_seen;
    l0 = last_seen;
    c0 = cycle_cnt;
    for (int i = 0; i < 1920; i++) begin
      send_pixel(24'($urandom), (i == 0), (i == 1919));
    end
    check("stream_cycles", 64'(cycle_cnt - c0), 64'd1920);
    drain();
    check("stream_words", 64'(words_seen - w0), 64'd1440);
    check("stream_tuser", 64'(user_seen - u0), 64'd1);
    check("stream_tlast", 64'(last_seen - l0), 64'd1);
    check("stream_end_tlast", 64'(last_last), 64'd1);

    repeat (3) @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
